// File: rtl/periph_init_pkg.sv
// Shared types and constants for the boot-time peripheral init sequencer:
// the register-write table, AXI encodings and the FSM state type.
package periph_init_pkg;

  localparam int INIT_ENTRIES = 4;
  localparam int IDX_W        = (INIT_ENTRIES > 1) ? $clog2(INIT_ENTRIES) : 1;

  typedef struct packed {
    logic [15:0] offset;
    logic [31:0] data;
  } init_entry_t;

  localparam init_entry_t INIT_TABLE [INIT_ENTRIES] = '{
    '{offset: 16'h1004, data: 32'h0000_001B},  // UART baud divisor
    '{offset: 16'h1008, data: 32'h0000_0003},  // UART tx/rx enable
    '{offset: 16'h2000, data: 32'h0000_00FF},  // peripheral IRQ enable mask
    '{offset: 16'h2004, data: 32'h0000_0001}   // IRQ controller global enable
  };

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_B,
    ST_DONE,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/periph_init_if.sv
// AXI4 write-only channel bundle between the init sequencer (master) and
// one slave input of the peripheral crossbar.
interface periph_init_if;

  logic        aw_valid;
  logic        aw_ready;
  logic [3:0]  aw_id;
  logic [30:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;

  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;

  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output w_valid, w_data, w_strb, w_last,
    output b_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  w_valid, w_data, w_strb, w_last,
    input  b_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp
  );

endinterface

// File: rtl/periph_init_seq.sv
// Boot-time sequencer: walks INIT_TABLE issuing single-beat AXI4 writes and
// reports done/error. Define PERIPH_INIT_AUTOSTART_EN to self-start after reset.
module periph_init_seq
  import periph_init_pkg::*;
#(
  parameter logic [30:0] BASE_ADDR      = 31'h6000_0000,
  parameter logic [3:0]  AXI_ID         = 4'h0,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             err_timeout,
  output logic [IDX_W-1:0] err_index,
  periph_init_if.master    bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aw_valid_q, aw_valid_d;
  logic             w_valid_q, w_valid_d;
  logic [30:0]      aw_addr_q, aw_addr_d;
  logic [31:0]      w_data_q, w_data_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             tmo_q, tmo_d;
  logic [IDX_W-1:0] eidx_q, eidx_d;
  logic             start_eff;
  logic             unused_b_id;

  assign unused_b_id = ^bus.b_id;

`ifdef PERIPH_INIT_AUTOSTART_EN
  // One-shot: high for exactly the first cycle after resetn is released.
  logic auto_pend_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) auto_pend_q <= 1'b1;
    else         auto_pend_q <= 1'b0;
  end
  assign start_eff = start | auto_pend_q;
`else
  assign start_eff = start;
`endif

  function automatic logic [30:0] entry_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + {15'd0, INIT_TABLE[i].offset};
  endfunction

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    done_d     = done_q;
    error_d    = error_q;
    tmo_d      = tmo_q;
    eidx_d     = eidx_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start_eff) begin
          state_d    = ST_ISSUE;
          idx_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          tmo_d      = 1'b0;
          eidx_d     = '0;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          aw_addr_d  = entry_addr('0);
          w_data_d   = INIT_TABLE[0].data;
        end
      end

      ST_ISSUE: begin
        // Each channel retires on its own handshake; leave once both have.
        if (bus.aw_ready) aw_valid_d = 1'b0;
        if (bus.w_ready)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          state_d = ST_WAIT_B;
          cnt_d   = '0;
        end
      end

      ST_WAIT_B: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.b_valid) begin
          if (bus.b_resp == RESP_OKAY) begin
            if (idx_q == IDX_W'(INIT_ENTRIES - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d    = ST_ISSUE;
              idx_d      = idx_q + IDX_W'(1);
              aw_valid_d = 1'b1;
              w_valid_d  = 1'b1;
              aw_addr_d  = entry_addr(idx_d);
              w_data_d   = INIT_TABLE[idx_d].data;
            end
          end else begin
            state_d = ST_FAIL;
            error_d = 1'b1;
            tmo_d   = 1'b0;
            eidx_d  = idx_q;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_FAIL;
          error_d = 1'b1;
          tmo_d   = 1'b1;
          eidx_d  = idx_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      tmo_q      <= 1'b0;
      eidx_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      tmo_q      <= tmo_d;
      eidx_q     <= eidx_d;
    end
  end

  assign bus.aw_valid = aw_valid_q;
  assign bus.aw_id    = AXI_ID;
  assign bus.aw_addr  = aw_addr_q;
  assign bus.aw_len   = 8'd0;
  assign bus.aw_size  = SIZE_4B;
  assign bus.aw_burst = BURST_INCR;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_data   = w_data_q;
  assign bus.w_strb   = 8'h0F;
  assign bus.w_last   = 1'b1;
  // FAIL keeps accepting responses so a late B beat cannot stall the crossbar.
  assign bus.b_ready  = (state_q == ST_WAIT_B) || (state_q == ST_FAIL);

  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT_B);
  assign done        = done_q;
  assign error       = error_q;
  assign err_timeout = tmo_q;
  assign err_index   = eidx_q;

endmodule
